// File: rtl/zebra_pkg.sv
// Shared types and default frame geometry for the zebra pattern generator
// and the zebra crossing detector.
package zebra_pkg;

  localparam int IMG_WIDTH_DEF  = 640;
  localparam int IMG_HEIGHT_DEF = 480;
  localparam int PIX_W_DEF      = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_HBLANK,
    ST_DONE
  } gen_state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/zebra_raster_counter.sv
// Raster x/y position with horizontal-blanking down-counter. Exposes the
// next-cycle coordinate so the generator can register its outputs.
module zebra_raster_counter
  import zebra_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int HBLANK     = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         adv,
  input  logic                         blank,
  output logic [cnt_w(IMG_WIDTH)-1:0]  x_nxt,
  output logic [cnt_w(IMG_HEIGHT)-1:0] y_nxt,
  output logic                         line_end,
  output logic                         frame_end,
  output logic                         blank_end
);

  localparam int XW = cnt_w(IMG_WIDTH);
  localparam int YW = cnt_w(IMG_HEIGHT);
  localparam int BW = cnt_w(HBLANK);
  localparam logic [BW-1:0] BLANK_LOAD = BW'((HBLANK > 0) ? HBLANK - 1 : 0);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [BW-1:0] blank_cnt;

  assign line_end  = (x == XW'(IMG_WIDTH - 1));
  assign frame_end = line_end && (y == YW'(IMG_HEIGHT - 1));
  assign blank_end = (blank_cnt == '0);

  always_comb begin
    x_nxt = x;
    y_nxt = y;
    if (clr) begin
      x_nxt = '0;
      y_nxt = '0;
    end else if (adv) begin
      if (line_end) begin
        x_nxt = '0;
        y_nxt = frame_end ? '0 : y + YW'(1);
      end else begin
        x_nxt = x + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      blank_cnt <= '0;
    end else begin
      x <= x_nxt;
      y <= y_nxt;
      if (adv && line_end && !frame_end)
        blank_cnt <= BLANK_LOAD;
      else if (blank && !blank_end)
        blank_cnt <= blank_cnt - BW'(1);
    end
  end

endmodule

// File: rtl/zebra_pattern_generator.sv
// Synthetic edge-frame source: one raster frame per accepted start, with
// horizontal boundary rows at top_row + k*stripe_h, k = 0..2*num_stripes.
//
//   state     | meaning
//   ST_IDLE   | waiting for start, config latched on accept
//   ST_ACTIVE | one pixel per cycle
//   ST_HBLANK | HBLANK idle cycles between lines
//   ST_DONE   | one-cycle done pulse
module zebra_pattern_generator
  import zebra_pkg::*;
#(
  parameter int           IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int           IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int           W          = PIX_W_DEF,
  parameter logic [W-1:0] EDGE_VAL   = {W{1'b1}},
  parameter int           MARGIN     = 32,
  parameter int           HBLANK     = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   num_stripes,
  input  logic [7:0]   stripe_h,
  input  logic [15:0]  top_row,
  output logic         busy,
  output logic         done,
  output logic         pixel_valid,
  output logic [W-1:0] edge_pixel,
  output logic         sof,
  output logic         eol
);

  localparam int XW = cnt_w(IMG_WIDTH);
  localparam int YW = cnt_w(IMG_HEIGHT);

  gen_state_t    state, state_n;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;
  logic          line_end, frame_end, blank_end;
  logic          clr, adv, blank, accept, row_adv;

  logic [7:0]    stripe_h_q, stripe_h_n;
  logic [8:0]    bounds_left, bounds_left_n;
  logic [15:0]   band_row, band_row_n;
  logic          row_hit, row_hit_n;

  logic          busy_d, done_d, valid_d, sof_d, eol_d;
  logic [W-1:0]  edge_d;

  assign accept  = (state == ST_IDLE) && start;
  assign clr     = (state == ST_IDLE) || (state == ST_DONE);
  assign adv     = (state == ST_ACTIVE);
  assign blank   = (state == ST_HBLANK);
  assign row_adv = adv && line_end && !frame_end;

  zebra_raster_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .HBLANK    (HBLANK)
  ) u_raster (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .adv      (adv),
    .blank    (blank),
    .x_nxt    (x_nxt),
    .y_nxt    (y_nxt),
    .line_end (line_end),
    .frame_end(frame_end),
    .blank_end(blank_end)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (start) state_n = ST_ACTIVE;
      ST_ACTIVE: begin
        if (frame_end)                      state_n = ST_DONE;
        else if (line_end && (HBLANK > 0))  state_n = ST_HBLANK;
      end
      ST_HBLANK: if (blank_end) state_n = ST_ACTIVE;
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // band_row counts rows down to the next boundary; bounds_left limits k.
  assign row_hit   = (band_row == '0) && (bounds_left != '0) && (stripe_h_q != '0);
  assign row_hit_n = (band_row_n == '0) && (bounds_left_n != '0) && (stripe_h_n != '0);

  always_comb begin
    stripe_h_n    = stripe_h_q;
    bounds_left_n = bounds_left;
    band_row_n    = band_row;
    if (accept) begin
      stripe_h_n    = stripe_h;
      bounds_left_n = {num_stripes, 1'b1};
      band_row_n    = top_row;
    end else if (row_adv) begin
      if (row_hit) begin
        bounds_left_n = bounds_left - 9'd1;
        band_row_n    = {8'd0, stripe_h_q} - 16'd1;
      end else begin
        band_row_n    = band_row - 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stripe_h_q  <= '0;
      bounds_left <= '0;
      band_row    <= '0;
    end else begin
      stripe_h_q  <= stripe_h_n;
      bounds_left <= bounds_left_n;
      band_row    <= band_row_n;
    end
  end

  // Outputs are computed from next-cycle state so they stay registered.
  always_comb begin
    busy_d  = (state_n != ST_IDLE);
    done_d  = (state_n == ST_DONE);
    valid_d = (state_n == ST_ACTIVE);
    sof_d   = valid_d && (x_nxt == '0) && (y_nxt == '0);
    eol_d   = valid_d && (x_nxt == XW'(IMG_WIDTH - 1));
    edge_d  = '0;
    if (valid_d && row_hit_n && (x_nxt >= XW'(MARGIN)) && (x_nxt < XW'(IMG_WIDTH - MARGIN)))
      edge_d = EDGE_VAL;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      pixel_valid <= 1'b0;
      sof         <= 1'b0;
      eol         <= 1'b0;
      edge_pixel  <= '0;
    end else begin
      busy        <= busy_d;
      done        <= done_d;
      pixel_valid <= valid_d;
      sof         <= sof_d;
      eol         <= eol_d;
      edge_pixel  <= edge_d;
    end
  end

endmodule
